// File: rtl/uart_rx_ack.sv
// uart_rx_ack: 8N1 serial receiver with ready/ack handshake, frame-error pulse and sticky overrun.
// Define UART_PARITY_EN to expect one even-parity bit between bit 7 and the stop bit.
module uart_rx_ack #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [13:0] BIT_END  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_END = 14'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD, S_RELEASE
    } state_t;

    state_t      state, state_n;
    logic        rx_meta, rxs, rxs_d;
    logic [13:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n, data_n;
    logic        ferr_n, ovr_n, stop_ok;

`ifdef UART_PARITY_EN
    logic par_err, par_err_n;
    assign stop_ok = rxs && !par_err;
`else
    assign stop_ok = rxs;
`endif

    assign ready = (state == S_HOLD);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 14'd1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data;
        ferr_n  = 1'b0;
`ifdef UART_PARITY_EN
        par_err_n = par_err;
`endif
        // Any start edge seen while a byte is pending (or not yet released) is lost.
        ovr_n = overrun | ((state == S_HOLD || state == S_RELEASE) && rxs_d && !rxs);
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    bit_n   = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
                    if (bit_idx == 3'd7) state_n = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_n     = '0;
                    par_err_n = rxs ^ (^shreg);
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (stop_ok) begin
                        data_n  = shreg;
                        state_n = S_HOLD;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                cnt_n = '0;
                if (ack) state_n = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until ack drops so one long ack cannot consume two bytes.
                cnt_n = '0;
                if (!ack) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= shreg_n;
            data      <= data_n;
            frame_err <= ferr_n;
            overrun   <= ovr_n;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err <= 1'b0;
        else      par_err <= par_err_n;
    end
`endif

endmodule
